// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller and the
// pipeline registers it steers: controller state encoding, the default
// memory-wait timeout and the NOP/bubble constants loaded on a flush.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } pipe_state_e;

   // Default number of consecutive memory-wait cycles tolerated before halting
   localparam int MEM_TIMEOUT_DEF = 15;

   // Wait counter width, wide enough for any timeout in 1..255
   localparam int WAIT_W = 8;

   // Contents a flushed IF/ID register loads (encodes a NOP)
   localparam logic [15:0] NOP_INSTR = 16'h0000;

   // Control bits a bubble carries: no register write, no memory access
   localparam logic BUBBLE_REG_WRITE = 1'b0;
   localparam logic BUBBLE_MEM_READ  = 1'b0;
   localparam logic BUBBLE_MEM_WRITE = 1'b0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs and pipeline-register controls of pipe_hazard_ctrl.
// master = pipeline side (drives hazard sources, receives controls),
// slave  = controller. Handshake: a memory access in MEM is pending while
// mem_req is high; it completes in the cycle mem_ready is high, and until
// then the controller holds PC..EX/MEM and lets MEM/WB take a bubble.
interface pipe_hazard_ctrl_if #(
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 16
);
   logic [ADDR_W-1:0] id_rs1;
   logic [ADDR_W-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic              ex_mem_read;
   logic [ADDR_W-1:0] ex_rd;
   logic              branch_taken;
   logic              mem_req;
   logic              mem_ready;

   logic              pc_en;
   logic              ifid_en;
   logic              idex_en;
   logic              exmem_en;
   logic              memwb_en;
   logic              ifid_flush;
   logic              idex_flush;
   logic              memwb_bubble;
   logic              halted;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;
   logic [1:0]        dbg_state;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
             branch_taken, mem_req, mem_ready,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
             idex_flush, memwb_bubble, halted, stall_cnt, flush_cnt, dbg_state
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
             branch_taken, mem_req, mem_ready,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
             idex_flush, memwb_bubble, halted, stall_cnt, flush_cnt, dbg_state
   );
endinterface

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use comparator: the ID instruction reads a register
// that the load currently in EX will write. Register 0 is compared like any
// other register.
module pipe_hazard_detect #(
   parameter int ADDR_W = 4
) (
   input  logic [ADDR_W-1:0] i_id_rs1,
   input  logic [ADDR_W-1:0] i_id_rs2,
   input  logic              i_id_use_rs1,
   input  logic              i_id_use_rs2,
   input  logic              i_ex_mem_read,
   input  logic [ADDR_W-1:0] i_ex_rd,
   output logic              o_load_use
);
   logic w_hit_rs1;
   logic w_hit_rs2;

   assign w_hit_rs1  = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
   assign w_hit_rs2  = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
   assign o_load_use = i_ex_mem_read && (w_hit_rs1 || w_hit_rs2);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 16-bit five-stage core.
// Registered state RUN / MEM_WAIT / HALT; all controls are combinational
// from state and inputs. Priority: HALT > memory freeze > taken branch >
// load-use > normal. Optional performance counters: PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 4,
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int CNT_W       = 16
) (
   input logic               CLK,
   input logic               reset,
   pipe_hazard_ctrl_if.slave bus
);
   localparam logic [1:0] S_RUN      = ST_RUN;
   localparam logic [1:0] S_MEM_WAIT = ST_MEM_WAIT;
   localparam logic [1:0] S_HALT     = ST_HALT;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [WAIT_W-1:0] w_wait_nxt;
   logic              r_halted;
   logic              w_halted_nxt;
   logic              w_freeze;
   logic              w_load_use;
   logic              w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
   logic              w_ifid_flush, w_idex_flush, w_memwb_bubble;

   assign w_freeze = bus.mem_req && !bus.mem_ready;

   pipe_hazard_detect #(.ADDR_W(ADDR_W)) u_detect (
      .i_id_rs1      (bus.id_rs1),
      .i_id_rs2      (bus.id_rs2),
      .i_id_use_rs1  (bus.id_use_rs1),
      .i_id_use_rs2  (bus.id_use_rs2),
      .i_ex_mem_read (bus.ex_mem_read),
      .i_ex_rd       (bus.ex_rd),
      .o_load_use    (w_load_use)
   );

   // Next state: enter MEM_WAIT on a freeze, count wait cycles, halt on timeout
   always_comb begin
      w_state_nxt  = r_state;
      w_wait_nxt   = r_wait_cnt;
      w_halted_nxt = r_halted;
      case (r_state)
         S_RUN: begin
            if (w_freeze) begin
               w_state_nxt = S_MEM_WAIT;
               w_wait_nxt  = WAIT_W'(1);
            end
         end
         S_MEM_WAIT: begin
            if (!w_freeze) begin
               w_state_nxt = S_RUN;
               w_wait_nxt  = '0;
            end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
               w_state_nxt  = S_HALT;
               w_halted_nxt = 1'b1;
            end else if (r_wait_cnt != '1) begin
               w_wait_nxt = r_wait_cnt + WAIT_W'(1);
            end
         end
         S_HALT: begin
            w_state_nxt = S_HALT;
         end
         default: begin
            w_state_nxt = S_RUN;
            w_wait_nxt  = '0;
         end
      endcase
   end

   // State, wait counter and sticky halt flag; only reset leaves HALT
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state    <= S_RUN;
         r_wait_cnt <= '0;
         r_halted   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_halted   <= w_halted_nxt;
      end
   end

   // Pipeline-register controls by priority; reset leaves every register enabled
   always_comb begin
      w_pc_en        = 1'b1;
      w_ifid_en      = 1'b1;
      w_idex_en      = 1'b1;
      w_exmem_en     = 1'b1;
      w_memwb_en     = 1'b1;
      w_ifid_flush   = 1'b0;
      w_idex_flush   = 1'b0;
      w_memwb_bubble = 1'b0;
      if (reset) begin
         w_pc_en = 1'b1;
      end else if (r_state == S_HALT) begin
         w_pc_en    = 1'b0;
         w_ifid_en  = 1'b0;
         w_idex_en  = 1'b0;
         w_exmem_en = 1'b0;
         w_memwb_en = 1'b0;
      end else if (w_freeze) begin
         // Everything up to EX/MEM holds; branch/load-use re-evaluated later
         w_pc_en        = 1'b0;
         w_ifid_en      = 1'b0;
         w_idex_en      = 1'b0;
         w_exmem_en     = 1'b0;
         w_memwb_bubble = 1'b1;
      end else if (bus.branch_taken) begin
         w_ifid_flush = 1'b1;
         w_idex_flush = 1'b1;
      end else if (w_load_use) begin
         w_pc_en      = 1'b0;
         w_ifid_en    = 1'b0;
         w_idex_flush = 1'b1;
      end
   end

   assign bus.pc_en        = w_pc_en;
   assign bus.ifid_en      = w_ifid_en;
   assign bus.idex_en      = w_idex_en;
   assign bus.exmem_en     = w_exmem_en;
   assign bus.memwb_en     = w_memwb_en;
   assign bus.ifid_flush   = w_ifid_flush;
   assign bus.idex_flush   = w_idex_flush;
   assign bus.memwb_bubble = w_memwb_bubble;
   assign bus.halted       = r_halted;
   assign bus.dbg_state    = r_state;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   // Saturating stall and flush cycle counters
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!w_pc_en && (r_state != S_HALT) && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if ((w_ifid_flush || w_idex_flush) && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign bus.stall_cnt = r_stall_cnt;
   assign bus.flush_cnt = r_flush_cnt;
`else
   assign bus.stall_cnt = {CNT_W{1'b0}};
   assign bus.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule
